// File: rtl/mccu_pkg.sv
// Shared types and defaults for the MCCU quota scheduler.
package mccu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        RELOAD = 2'd2
    } state_t;

    localparam int DEF_N_CORES  = 4;
    localparam int DEF_QUOTA_W  = 32;
    localparam int DEF_PERIOD_W = 32;
    localparam int DEF_CNT_W    = 16;

    // Width of a core index; a single core still needs one bit of index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mccu_period_timer.sv
// Period down-counter: a period of P cycles raises expire once every P
// running cycles; P == 0 disables automatic expiry.
module mccu_period_timer #(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                expire
);

    logic [PERIOD_W-1:0] remain;
    logic [PERIOD_W-1:0] reload_val;

    assign reload_val = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign expire     = run && (remain == '0) && (period != '0);

    // Restart on load or expiry, otherwise count down while running and rest at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain <= '0;
        end else if (load || expire) begin
            remain <= reload_val;
        end else if (run && (remain != '0)) begin
            remain <= remain - PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/mccu_quota_sched.sv
// Periodic quota scheduler: sole writer of MCCU per-core quotas. At every
// period boundary it snapshots the exhausted-core mask and rewrites all
// quotas over a valid/ready port, core 0 first.
module mccu_quota_sched
    import mccu_pkg::*;
#(
    parameter int N_CORES  = DEF_N_CORES,
    parameter int QUOTA_W  = DEF_QUOTA_W,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int CNT_W    = DEF_CNT_W,
    localparam int IDX_W   = idx_width(N_CORES)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [PERIOD_W-1:0]        period_i,
    input  logic                       sw_reload_i,
    input  logic [N_CORES*QUOTA_W-1:0] quota_limit_i,
    input  logic [N_CORES-1:0]         quota_int_i,
    output logic                       upd_valid_o,
    output logic [IDX_W-1:0]           upd_core_o,
    output logic [QUOTA_W-1:0]         upd_quota_o,
    input  logic                       upd_ready_i,
    output logic [N_CORES-1:0]         last_exhausted_o,
    output logic [CNT_W-1:0]           period_cnt_o,
    output logic                       busy_o,
    output logic                       overrun_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CORES - 1);

    state_t                     state;
    logic                       in_reload;
    logic [IDX_W-1:0]           idx;
    logic [N_CORES*QUOTA_W-1:0] limits;
    logic [N_CORES-1:0]         sticky;
    logic                       pending;
    logic                       expire;
    logic                       sw_accept;
    logic                       boundary;
    logic                       timer_load;

    // A software reload only counts while counting with the scheduler enabled.
    assign sw_accept  = (state == COUNT) && enable_i && sw_reload_i;
    assign boundary   = expire || sw_accept;
    assign timer_load = ((state == IDLE) && enable_i) || sw_accept;

    assign upd_valid_o = in_reload;
    assign busy_o      = in_reload;
    assign upd_core_o  = idx;
    assign upd_quota_o = limits[int'(idx)*QUOTA_W +: QUOTA_W];

    mccu_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (timer_load),
        .run    (state != IDLE),
        .period (period_i),
        .expire (expire)
    );

    // Sequencer: in_reload is a registered copy of (state == RELOAD) so the
    // write-port valid comes straight from a flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            in_reload <= 1'b0;
            idx       <= '0;
            limits    <= '0;
            pending   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state     <= RELOAD;
                        in_reload <= 1'b1;
                        idx       <= '0;
                        limits    <= quota_limit_i;
                    end
                end
                COUNT: begin
                    if (!enable_i) begin
                        state <= IDLE;
                    end else if (boundary) begin
                        state     <= RELOAD;
                        in_reload <= 1'b1;
                        idx       <= '0;
                        limits    <= quota_limit_i;
                    end
                end
                RELOAD: begin
                    if (expire) begin
                        overrun_o <= 1'b1;
                        pending   <= 1'b1;
                    end
                    if (upd_ready_i) begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (!enable_i) begin
                                state     <= IDLE;
                                in_reload <= 1'b0;
                                pending   <= 1'b0;
                            end else if (pending || expire) begin
                                limits  <= quota_limit_i;
                                pending <= 1'b0;
                            end else begin
                                state     <= COUNT;
                                in_reload <= 1'b0;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_reload <= 1'b0;
                end
            endcase
        end
    end

    // Exhaustion bookkeeping: accumulate interrupts, snapshot them at each boundary.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sticky           <= '0;
            last_exhausted_o <= '0;
            period_cnt_o     <= '0;
        end else if (boundary) begin
            last_exhausted_o <= sticky | quota_int_i;
            sticky           <= '0;
            if (expire && (period_cnt_o != '1)) begin
                period_cnt_o <= period_cnt_o + CNT_W'(1);
            end
        end else begin
            sticky <= sticky | quota_int_i;
        end
    end

endmodule

// File: tb/tb_mccu_quota_sched.sv
// Bench for mccu_quota_sched: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the scheduler.
module tb_mccu_quota_sched;

    localparam int N  = 4;
    localparam int QW = 32;
    localparam int PW = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [PW-1:0] period;
    logic          sw_reload;
    logic [N*QW-1:0] limits;
    logic [N-1:0]  qint;
    logic          upd_valid;
    logic [1:0]    upd_core;
    logic [QW-1:0] upd_quota;
    logic          ready;
    logic [N-1:0]  last_exh;
    logic [CW-1:0] pcnt;
    logic          busy;
    logic          overrun;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: phase flags, position in the write sequence,
    // cycles left in the current period and the bookkeeping outputs.
    bit            m_rel, m_cnt_st, m_pend, m_ovr;
    int            m_pos, m_pc;
    longint        m_left;
    logic [N-1:0]  m_sticky, m_last;
    logic [QW-1:0] m_lim [N];

    mccu_quota_sched #(
        .N_CORES  (N),
        .QUOTA_W  (QW),
        .PERIOD_W (PW),
        .CNT_W    (CW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .period_i         (period),
        .sw_reload_i      (sw_reload),
        .quota_limit_i    (limits),
        .quota_int_i      (qint),
        .upd_valid_o      (upd_valid),
        .upd_core_o       (upd_core),
        .upd_quota_o      (upd_quota),
        .upd_ready_i      (ready),
        .last_exhausted_o (last_exh),
        .period_cnt_o     (pcnt),
        .busy_o           (busy),
        .overrun_o        (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rel = 0; m_cnt_st = 0; m_pend = 0; m_ovr = 0;
        m_pos = 0; m_pc = 0; m_left = 0;
        m_sticky = '0; m_last = '0;
        for (int k = 0; k < N; k++) m_lim[k] = '0;
    endtask

    task automatic latch_limits();
        for (int k = 0; k < N; k++) m_lim[k] = limits[k*QW +: QW];
    endtask

    // Advance the model by one clock using the inputs presented before the edge.
    task automatic model_step();
        bit idle, ex, sw_ok;
        idle  = !m_rel && !m_cnt_st;
        ex    = !idle && (m_left == 0) && (period != 0);
        sw_ok = m_cnt_st && enable && sw_reload;
        if (ex || sw_ok) begin
            m_last   = m_sticky | qint;
            m_sticky = '0;
            if (ex && m_pc < CNT_MAX) m_pc++;
        end else begin
            m_sticky = m_sticky | qint;
        end
        if (idle ? enable : (ex || sw_ok))
            m_left = (period == 0) ? 0 : longint'(period) - 1;
        else if (!idle && m_left > 0)
            m_left--;
        if (idle) begin
            if (enable) begin m_rel = 1; m_pos = 0; latch_limits(); end
        end else if (m_cnt_st) begin
            if (!enable) m_cnt_st = 0;
            else if (ex || sw_ok) begin m_cnt_st = 0; m_rel = 1; m_pos = 0; latch_limits(); end
        end else begin
            if (ex) begin m_ovr = 1; m_pend = 1; end
            if (ready) begin
                if (m_pos == N-1) begin
                    m_pos = 0;
                    if (!enable) begin m_rel = 0; m_pend = 0; end
                    else if (m_pend) begin m_pend = 0; latch_limits(); end
                    else begin m_rel = 0; m_cnt_st = 1; end
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("valid",      64'(upd_valid), 64'(m_rel));
        chk("busy",       64'(busy),      64'(m_rel));
        chk("core",       64'(upd_core),  64'(m_pos));
        chk("quota",      64'(upd_quota), 64'(m_lim[m_pos]));
        chk("last_exh",   64'(last_exh),  64'(m_last));
        chk("period_cnt", 64'(pcnt),      64'(m_pc));
        chk("overrun",    64'(overrun),   64'(m_ovr));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},   64'(upd_valid), 64'(0));
        chk({tag, "_core"},    64'(upd_core),  64'(0));
        chk({tag, "_quota"},   64'(upd_quota), 64'(0));
        chk({tag, "_last"},    64'(last_exh),  64'(0));
        chk({tag, "_cnt"},     64'(pcnt),      64'(0));
        chk({tag, "_busy"},    64'(busy),      64'(0));
        chk({tag, "_overrun"}, 64'(overrun),   64'(0));
    endtask

    // Run until the current cycle is a counting cycle on which the period expires.
    task automatic wait_expiry_cycle(input string tag);
        int g = 0;
        while (!(m_cnt_st && m_left == 0 && period != 0) && g < 100) begin
            cycle();
            g++;
        end
        chk(tag, 64'(g < 100), 64'(1));
    endtask

    task automatic wait_valid(input string tag);
        int g = 0;
        while (!upd_valid && g < 100) begin
            cycle();
            g++;
        end
        chk(tag, 64'(g < 100), 64'(1));
    endtask

    initial begin
        int n;
        logic [CW-1:0] saved_cnt;

        rst = 1; enable = 0; period = '0; sw_reload = 0; ready = 0; qint = '0;
        limits = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");

        // First sequence: four writes, then the next one a full period later.
        rst = 0; enable = 1; ready = 1; period = PW'(20);
        limits = {32'd10, 32'd20, 32'd30, 32'd40};
        for (int k = 0; k < N; k++) begin
            cycle();
            chk("seq1_valid", 64'(upd_valid), 64'(1));
            chk("seq1_core",  64'(upd_core),  64'(k));
            chk("seq1_quota", 64'(upd_quota), 64'(40 - 10*k));
        end
        n = 0;
        do begin cycle(); n++; end while (!upd_valid && n < 40);
        chk("restart_gap", 64'(n), 64'(17));
        chk("cnt_after_first", 64'(pcnt), 64'(1));

        // Stall on core 2 for three cycles.
        cycle();
        cycle();
        chk("pre_stall_core", 64'(upd_core), 64'(2));
        ready = 0;
        repeat (3) begin
            cycle();
            chk("stall_valid", 64'(upd_valid), 64'(1));
            chk("stall_core",  64'(upd_core),  64'(2));
            chk("stall_quota", 64'(upd_quota), 64'(20));
        end
        ready = 1;
        cycle();
        chk("post_stall_core", 64'(upd_core), 64'(3));
        cycle();
        chk("post_seq_idle_valid", 64'(upd_valid), 64'(0));

        // Interrupt capture: core 1 mid-period, core 3 on the expiry cycle.
        qint = 4'b0010;
        cycle();
        qint = '0;
        wait_expiry_cycle("wait_exp_a");
        qint = 4'b1000;
        cycle();
        qint = '0;
        chk("exh_mask", 64'(last_exh), 64'(4'b1010));
        wait_expiry_cycle("wait_exp_b");
        cycle();
        chk("exh_clear", 64'(last_exh), 64'(0));
        chk("cnt_three", 64'(pcnt), 64'(3));

        // Overrun: short period while the MCCU refuses writes.
        repeat (4) cycle();
        ready = 0; period = PW'(3);
        wait_valid("wait_overrun_seq");
        repeat (10) cycle();
        chk("overrun_set",  64'(overrun), 64'(1));
        chk("overrun_busy", 64'(busy),    64'(1));
        ready = 1; period = '0;
        for (int k = 1; k <= 2*N; k++) begin
            cycle();
            chk("overrun_core", 64'(upd_core), 64'(k % N));
            chk("overrun_busy_hold", 64'(busy), 64'(k < 2*N));
        end

        // Software reload with automatic reloads disabled.
        saved_cnt = pcnt;
        sw_reload = 1;
        cycle();
        sw_reload = 0;
        chk("sw_start_busy", 64'(busy), 64'(1));
        chk("sw_start_core", 64'(upd_core), 64'(0));
        cycle();
        sw_reload = 1;
        cycle();
        sw_reload = 0;
        repeat (2) cycle();
        repeat (5) begin
            cycle();
            chk("sw_ignored_busy", 64'(busy), 64'(0));
        end
        chk("sw_cnt_same", 64'(pcnt), 64'(saved_cnt));

        // Asynchronous reset in the middle of a sequence.
        sw_reload = 1;
        cycle();
        sw_reload = 0;
        cycle();
        chk("pre_reset_core", 64'(upd_core), 64'(1));
        #2;
        rst = 1;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        cycle();
        chk("restart_valid", 64'(upd_valid), 64'(1));
        chk("restart_core",  64'(upd_core),  64'(0));

        // Random traffic against the model.
        repeat (500) begin
            enable    = ($urandom_range(0, 15) != 0);
            sw_reload = ($urandom_range(0, 7) == 0);
            ready     = ($urandom_range(0, 1) == 1);
            qint      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
            if ($urandom_range(0, 31) == 0) period = PW'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) limits = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        // Period counter saturation with an expiry every running cycle.
        enable = 1; sw_reload = 0; ready = 1; qint = '0; period = PW'(1);
        repeat (40) cycle();
        chk("cnt_saturated", 64'(pcnt), 64'(CNT_MAX));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
